// File: rtl/goomba_spawner.sv
// Spawn controller for a pool of goomba slots: counts scroll columns, walks the
// external spawn table, starts the lowest free slot when an entry comes into view,
// and kills every slot on level restart or when Mario is killed.
module goomba_spawner #(
  parameter int         NUM_SLOTS = 4,
  parameter int         VIEW_COLS = 12,
  parameter logic [9:0] SPAWN_X   = 10'd499
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 frame_clk,
  input  logic                 Shift,
  input  logic                 level_start,
  input  logic                 spawn_valid,
  input  logic [7:0]           spawn_col,
  input  logic [9:0]           spawn_y,
  input  logic [NUM_SLOTS-1:0] isAlive,
  input  logic [NUM_SLOTS-1:0] kill_Mario,
  output logic [3:0]           spawn_idx,
  output logic [NUM_SLOTS-1:0] start,
  output logic [NUM_SLOTS-1:0] kill,
  output logic [9:0]           spawnX,
  output logic [9:0]           spawnY,
  output logic [7:0]           scroll_col,
  output logic                 mario_dead
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SCAN  = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4,
    HALT  = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic                 frame_q;
  logic [3:0]           spawn_idx_q, spawn_idx_d;
  logic [7:0]           scroll_q, scroll_d;
  logic [NUM_SLOTS-1:0] start_q, start_d;
  logic [NUM_SLOTS-1:0] kill_q, kill_d;
  logic [9:0]           spawnx_q, spawnx_d;
  logic [9:0]           spawny_q, spawny_d;
  logic                 dead_q, dead_d;

  logic                 frame_rise;
  logic                 active;
  logic                 death_hit;
  logic                 entry_past;
  logic                 entry_in_range;
  logic [NUM_SLOTS-1:0] free_avail;
  logic [NUM_SLOTS-1:0] free_onehot;
  logic                 free_found;

  assign frame_rise = frame_clk & ~frame_q;
  assign active     = (state_q == SCAN) || (state_q == ISSUE) ||
                      (state_q == WAIT) || (state_q == DONE);
  assign death_hit  = |kill_Mario;
  assign entry_past = spawn_col < scroll_q;
  // 9-bit sum so a scroll near 255 cannot wrap the view window
  assign entry_in_range = {1'b0, spawn_col} <= ({1'b0, scroll_q} + 9'(VIEW_COLS));
  // a slot being killed this cycle is not yet free, even if isAlive is low
  assign free_avail = ~isAlive & ~kill_q;

  // Pick the lowest-index free slot as a one-hot vector
  always_comb begin
    free_onehot = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (free_avail[i]) begin
        free_onehot    = '0;
        free_onehot[i] = 1'b1;
      end
    end
  end
  assign free_found = |free_onehot;

  // State and datapath registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      frame_q     <= 1'b0;
      spawn_idx_q <= '0;
      scroll_q    <= '0;
      start_q     <= '0;
      kill_q      <= '0;
      spawnx_q    <= '0;
      spawny_q    <= '0;
      dead_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_clk;
      spawn_idx_q <= spawn_idx_d;
      scroll_q    <= scroll_d;
      start_q     <= start_d;
      kill_q      <= kill_d;
      spawnx_q    <= spawnx_d;
      spawny_q    <= spawny_d;
      dead_q      <= dead_d;
    end
  end

  // Next-state logic: level_start beats death, death beats table walking
  always_comb begin
    state_d = state_q;
    if (level_start) begin
      state_d = SCAN;
    end else if (active && death_hit) begin
      state_d = HALT;
    end else begin
      case (state_q)
        SCAN: begin
          if (!spawn_valid) begin
            state_d = DONE;
          end else if (!entry_past && entry_in_range && free_found) begin
            state_d = ISSUE;
          end
        end
        ISSUE:   state_d = WAIT;
        WAIT:    state_d = SCAN;
        default: state_d = state_q;
      endcase
    end
  end

  // Output and datapath next values; start and kill default to a single-cycle pulse
  always_comb begin
    spawn_idx_d = spawn_idx_q;
    scroll_d    = scroll_q;
    start_d     = '0;
    kill_d      = '0;
    spawnx_d    = spawnx_q;
    spawny_d    = spawny_q;
    dead_d      = dead_q;

    if (active && frame_rise && Shift && (scroll_q != 8'hFF)) begin
      scroll_d = scroll_q + 8'd1;
    end

    if (level_start) begin
      spawn_idx_d = '0;
      scroll_d    = '0;
      dead_d      = 1'b0;
      kill_d      = '1;
    end else if (active && death_hit) begin
      dead_d = 1'b1;
      kill_d = '1;
    end else begin
      case (state_q)
        SCAN: begin
          if (spawn_valid) begin
            if (entry_past) begin
              spawn_idx_d = spawn_idx_q + 4'd1;
            end else if (entry_in_range && free_found) begin
              start_d  = free_onehot;
              spawnx_d = SPAWN_X;
              spawny_d = spawn_y;
            end
          end
        end
        ISSUE:   spawn_idx_d = spawn_idx_q + 4'd1;
        default: ;
      endcase
    end
  end

  assign spawn_idx  = spawn_idx_q;
  assign start      = start_q;
  assign kill       = kill_q;
  assign spawnX     = spawnx_q;
  assign spawnY     = spawny_q;
  assign scroll_col = scroll_q;
  assign mario_dead = dead_q;

endmodule

// File: tb/tb_goomba_spawner.sv
// Directed bench for goomba_spawner with a small spawn table modelled as a ROM.
module tb_goomba_spawner;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_clk;
  logic       Shift;
  logic       level_start;
  logic       spawn_valid;
  logic [7:0] spawn_col;
  logic [9:0] spawn_y;
  logic [3:0] isAlive;
  logic [3:0] kill_Mario;
  logic [3:0] spawn_idx;
  logic [3:0] start;
  logic [3:0] kill;
  logic [9:0] spawnX;
  logic [9:0] spawnY;
  logic [7:0] scroll_col;
  logic       mario_dead;

  logic       tbl_valid [16];
  logic [7:0] tbl_col   [16];
  logic [9:0] tbl_y     [16];

  int checks = 0;
  int errors = 0;

  goomba_spawner dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_clk  (frame_clk),
    .Shift      (Shift),
    .level_start(level_start),
    .spawn_valid(spawn_valid),
    .spawn_col  (spawn_col),
    .spawn_y    (spawn_y),
    .isAlive    (isAlive),
    .kill_Mario (kill_Mario),
    .spawn_idx  (spawn_idx),
    .start      (start),
    .kill       (kill),
    .spawnX     (spawnX),
    .spawnY     (spawnY),
    .scroll_col (scroll_col),
    .mario_dead (mario_dead)
  );

  always #5 Clk = ~Clk;

  // combinational spawn-table ROM
  assign spawn_valid = tbl_valid[spawn_idx];
  assign spawn_col   = tbl_col[spawn_idx];
  assign spawn_y     = tbl_y[spawn_idx];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s = %0d", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic frame_tick(input logic sh);
    Shift     = sh;
    frame_clk = 1'b1;
    tick();
    frame_clk = 1'b0;
    tick();
    Shift     = 1'b0;
  endtask

  task automatic clear_table();
    for (int i = 0; i < 16; i++) begin
      tbl_valid[i] = 1'b0;
      tbl_col[i]   = 8'd0;
      tbl_y[i]     = 10'd0;
    end
  endtask

  initial begin
    Reset = 1'b1; frame_clk = 1'b0; Shift = 1'b0; level_start = 1'b0;
    isAlive = 4'b0000; kill_Mario = 4'b0000;
    clear_table();
    tbl_valid[0] = 1'b1; tbl_col[0] = 8'd3;  tbl_y[0] = 10'd400;
    tbl_valid[1] = 1'b1; tbl_col[1] = 8'd20; tbl_y[1] = 10'd360;

    // reset state
    tick(); tick();
    check("rst_idx", 32'(spawn_idx), 0);
    check("rst_scroll", 32'(scroll_col), 0);
    check("rst_start", 32'(start), 0);
    check("rst_kill", 32'(kill), 0);
    check("rst_spawnX", 32'(spawnX), 0);
    check("rst_spawnY", 32'(spawnY), 0);
    check("rst_dead", 32'(mario_dead), 0);
    Reset = 1'b0;
    tick();
    frame_tick(1'b1);
    check("idle_no_scroll", 32'(scroll_col), 0);

    // level start, first spawn of entry 0
    level_start = 1'b1; tick(); level_start = 1'b0;
    check("ls_kill", 32'(kill), 32'hF);
    check("ls_start", 32'(start), 0);
    tick();
    check("ls_kill_clr", 32'(kill), 0);
    check("ls_start_blk", 32'(start), 0);
    tick();
    check("sp0_start", 32'(start), 32'h1);
    check("sp0_x", 32'(spawnX), 499);
    check("sp0_y", 32'(spawnY), 400);
    isAlive = 4'b0001;
    tick();
    check("sp0_start_clr", 32'(start), 0);
    check("sp0_idx", 32'(spawn_idx), 1);
    tick(); tick(); tick();
    check("col20_wait_start", 32'(start), 0);
    check("col20_wait_idx", 32'(spawn_idx), 1);

    // scroll into view of col 20
    for (int i = 0; i < 7; i++) frame_tick(1'b1);
    check("scroll7", 32'(scroll_col), 7);
    check("scroll7_start", 32'(start), 0);
    frame_tick(1'b1);
    check("scroll8", 32'(scroll_col), 8);
    check("sp1_start", 32'(start), 32'h2);
    check("sp1_y", 32'(spawnY), 360);
    isAlive = 4'b0011;
    tick();
    check("sp1_idx", 32'(spawn_idx), 2);
    tick(); tick(); tick();
    check("done_idx", 32'(spawn_idx), 2);
    check("done_start", 32'(start), 0);
    frame_tick(1'b1);
    check("done_scroll", 32'(scroll_col), 9);

    // stall with all slots alive
    clear_table();
    tbl_valid[0] = 1'b1; tbl_col[0] = 8'd1;  tbl_y[0] = 10'd300;
    tbl_valid[1] = 1'b1; tbl_col[1] = 8'd40; tbl_y[1] = 10'd0;
    isAlive = 4'b1111;
    level_start = 1'b1; tick(); level_start = 1'b0;
    check("ls2_kill", 32'(kill), 32'hF);
    check("ls2_scroll", 32'(scroll_col), 0);
    tick(); tick(); tick();
    check("stall_start", 32'(start), 0);
    check("stall_idx", 32'(spawn_idx), 0);
    isAlive = 4'b1011;
    tick();
    check("stall_rel_start", 32'(start), 32'h4);
    check("stall_rel_y", 32'(spawnY), 300);
    isAlive = 4'b1111;
    tick();
    check("stall_rel_idx", 32'(spawn_idx), 1);
    tick(); tick();

    // skip an entry that has scrolled past
    for (int i = 0; i < 5; i++) frame_tick(1'b1);
    check("skip_scroll", 32'(scroll_col), 5);
    check("skip_idx_pre", 32'(spawn_idx), 1);
    isAlive = 4'b0000;
    tbl_col[1] = 8'd2;
    tick();
    check("skip_idx", 32'(spawn_idx), 2);
    check("skip_start", 32'(start), 0);
    tick();
    check("skip_start2", 32'(start), 0);

    // Mario death
    kill_Mario = 4'b0010; tick(); kill_Mario = 4'b0000;
    check("death_kill", 32'(kill), 32'hF);
    check("death_dead", 32'(mario_dead), 1);
    check("death_start", 32'(start), 0);
    tick();
    check("halt_kill", 32'(kill), 0);
    check("halt_dead", 32'(mario_dead), 1);
    frame_tick(1'b1);
    check("halt_scroll", 32'(scroll_col), 5);
    clear_table();
    tbl_valid[0] = 1'b1; tbl_col[0] = 8'd0; tbl_y[0] = 10'd200;
    isAlive = 4'b1111;
    level_start = 1'b1; tick(); level_start = 1'b0;
    check("restart_dead", 32'(mario_dead), 0);
    check("restart_scroll", 32'(scroll_col), 0);
    check("restart_kill", 32'(kill), 32'hF);
    tick();

    // level_start coincident with kill_Mario and a spawnable entry
    isAlive = 4'b0000;
    level_start = 1'b1; kill_Mario = 4'b0001; tick();
    level_start = 1'b0; kill_Mario = 4'b0000;
    check("coin_kill", 32'(kill), 32'hF);
    check("coin_dead", 32'(mario_dead), 0);
    check("coin_start", 32'(start), 0);
    check("coin_idx", 32'(spawn_idx), 0);
    tick();
    check("coin_start2", 32'(start), 0);
    tick();
    check("coin_spawn", 32'(start), 32'h1);
    check("coin_spawn_y", 32'(spawnY), 200);
    isAlive = 4'b0001;
    tick();
    check("coin_idx1", 32'(spawn_idx), 1);

    // saturation of scroll column
    for (int i = 0; i < 300; i++) frame_tick(1'b1);
    check("scroll_sat", 32'(scroll_col), 255);
    check("sat_idx", 32'(spawn_idx), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/goomba_spawner.md
Name: goomba_spawner

Overview:
- Upstream controller for a pool of goomba enemy slots.
- Tracks horizontal scroll position in 40-pixel world columns and walks an external spawn table addressed by spawn_idx.
- When a table entry comes into view, issues a one-cycle start with spawnX/spawnY to the lowest free slot.
- Also kills all slots on level restart and when any slot reports it has killed Mario.

Parameters:
- NUM_SLOTS, 4, number of goomba instances driven (1..8).
- VIEW_COLS, 12, columns visible right of scroll_col; an entry spawns when spawn_col <= scroll_col + VIEW_COLS.
- SPAWN_X, 10'd499, X position given to every spawned goomba (right screen edge inside play area).

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- frame_clk  in  1  frame tick; rising edge detected internally, same scheme as the enemy slots.
- Shift  in  1  screen scrolled one column (40 px); sampled only on frame_clk rising edge.
- level_start  in  1  one-cycle pulse: begin/restart level.
- spawn_valid  in  1  current table entry exists (0 = end of table).
- spawn_col  in  8  world column of current entry.
- spawn_y  in  10  ground Y of current entry (slot subtracts its own size).
- isAlive  in  NUM_SLOTS  per-slot alive flags.
- kill_Mario  in  NUM_SLOTS  per-slot Mario-killed flags.
- spawn_idx  out  4  table address, combinational ROM read.
- start  out  NUM_SLOTS  one-hot spawn pulse, registered.
- kill  out  NUM_SLOTS  kill pulse to slots, registered.
- spawnX  out  10  spawn X, valid while start != 0.
- spawnY  out  10  spawn Y, valid while start != 0.
- scroll_col  out  8  current scroll column.
- mario_dead  out  1  sticky death flag.

Behaviour:
- Reset: state=IDLE; spawn_idx=0, scroll_col=0, start=0, kill=0, spawnX=0, spawnY=0, mario_dead=0.
- States: IDLE, SCAN, ISSUE, WAIT, DONE, HALT.
- level_start, from any state, has highest priority:
  - next cycle: spawn_idx=0, scroll_col=0, mario_dead=0, kill=all ones for exactly one cycle, state=SCAN.
  - Overrides simultaneous kill_Mario, Shift, and an in-progress spawn; start is forced to 0.
- IDLE: wait for level_start only; Shift ignored.
- Scroll counting:
  - In SCAN/ISSUE/WAIT/DONE, each frame_clk rising edge with Shift=1 increments scroll_col by 1.
  - scroll_col saturates at 255, no wrap.
  - Ignored in IDLE/HALT.
- SCAN, evaluated each Clk:
  - spawn_valid=0 -> DONE.
  - spawn_col < scroll_col (entry scrolled past) -> spawn_idx+1, stay SCAN, no start.
  - spawn_col <= scroll_col+VIEW_COLS (compare in 9 bits) and a free slot exists -> ISSUE.
    - Free slot = lowest index with isAlive=0 and kill not asserted this cycle.
    - Latch slot, spawnX=SPAWN_X, spawnY=spawn_y.
  - In range but no free slot -> stall in SCAN, entry retained, no skip.
  - Otherwise stay SCAN.
- ISSUE: start[slot]=1 for exactly this one cycle; spawn_idx+1 at its end; -> WAIT.
- WAIT: one cycle, start=0, lets slot isAlive rise and ROM settle; -> SCAN.
  - Latency: entry in range to start high = 1 cycle; to next entry evaluated = 3 cycles.
- DONE: no spawns; scroll counting continues; exit only via level_start.
- Mario death:
  - Any kill_Mario bit=1 in SCAN/ISSUE/WAIT/DONE -> next cycle mario_dead=1, kill=all ones for one cycle, start=0, state=HALT.
  - A start in the same cycle is still delivered; the kill on the next cycle clears that slot.
- HALT: outputs frozen (kill=0, start=0); mario_dead held; exit only via level_start.
- spawn_idx is 4 bits and wraps 15->0 only if the table never reports spawn_valid=0; tables must terminate with spawn_valid=0.

Test Plan:
- Reset, then level_start; table {col 3,y 400},{col 20,y 360},end -> cycle 1 start=0001, spawnX=499, spawnY=400; after WAIT, spawn_idx=1; col 20 not spawned while scroll_col<8.
- 8 Shift frame ticks -> scroll_col=8, start=0010 (slot0 still alive), spawnY=360, then spawn_idx=2, state DONE.
- All 4 isAlive=1, entry in range -> start stays 0, spawn_idx held; drop isAlive[2] -> start=0100 next cycle.
- Entry col 2 with scroll_col=5 -> skipped: spawn_idx+1, no start pulse.
- kill_Mario=0010 -> next cycle kill=1111 for one cycle, mario_dead=1; further Shift leaves scroll_col unchanged; level_start clears mario_dead and scroll_col to 0.
- level_start coincident with kill_Mario and in-range entry -> kill=1111, mario_dead=0, start=0, spawn_idx=0, state SCAN; 300 Shift ticks -> scroll_col=255.
